// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, tick divider and
// counter width helpers, and the 2-of-3 vote used on mid-bit samples.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        int d;
        d = clk_freq / (baud * os);
        if (d < 1) begin
            return 1;
        end else begin
            return d;
        end
    endfunction

    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_clk_gen.sv
// Oversampling tick enable: one sys_clk-wide pulse every DIV cycles, realigned
// to zero whenever a start edge is detected.
module uart_rx_clk_gen
    import uart_rx_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 200_000_000,
    parameter int BAUD_RATE    = 19200,
    parameter int OVERSAMPLE   = 16
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int DIV   = calc_div(SYS_CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int DIV_W = cnt_width(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] div_cnt_r;
    logic             tick_r;

    // Divider counter and registered tick pulse
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            div_cnt_r <= {DIV_W{1'b0}};
            tick_r    <= 1'b0;
        end else if (restart) begin
            div_cnt_r <= {DIV_W{1'b0}};
            tick_r    <= 1'b0;
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= {DIV_W{1'b0}};
            tick_r    <= 1'b1;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
            tick_r    <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_rx_top.sv
// UART receiver: synchronizes the RX line, votes three mid-bit samples per bit
// and presents each completed frame with a one-cycle done (and frame_err) pulse.
module uart_rx_top
    import uart_rx_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 200_000_000,
    parameter int BAUD_RATE    = 19200,
    parameter int FRAME_WIDTH  = 8,
    parameter int OVERSAMPLE   = 16
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   uart_rx_din,
    output logic [0:FRAME_WIDTH-1] uart_rx_dout,
    output logic                   uart_rx_done,
    output logic                   uart_rx_frame_err,
    output logic                   uart_rx_busy
);

    localparam int BCNT_W = cnt_width(OVERSAMPLE);
    localparam int IDX_W  = cnt_width(FRAME_WIDTH);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
    localparam logic [BCNT_W-1:0] VOTE_A    = BCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BCNT_W-1:0] VOTE_B    = BCNT_W'(OVERSAMPLE / 2);
    localparam logic [BCNT_W-1:0] VOTE_C    = BCNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_WIDTH - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

    logic                   sync1_r, sync2_r, prev_r;
    logic                   fall_s, tick_s, restart_s;
    logic [BCNT_W-1:0]      bcnt_r, bcnt_nxt_s;
    logic                   vote_a_r, vote_b_r, vote_s;
    logic                   decide_s, wrap_s;
    rx_state_t              state_r, state_nxt_s;
    logic [IDX_W-1:0]       idx_r;
    logic                   idx_clr_s, idx_inc_s, bit_wr_s, load_s;
    logic [0:FRAME_WIDTH-1] shift_r, dout_r;
    logic                   done_r, err_r, busy_r;

    uart_rx_clk_gen #(
        .SYS_CLK_FREQ (SYS_CLK_FREQ),
        .BAUD_RATE    (BAUD_RATE),
        .OVERSAMPLE   (OVERSAMPLE)
    ) u_clk_gen (
        .sys_clk (sys_clk),
        .reset   (reset),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // Two-FF synchronizer plus edge history; idle-high reset avoids a false start
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= uart_rx_din;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Sample points compare the post-increment count, so tick N of a bit has index N
    assign fall_s     = prev_r & ~sync2_r;
    assign bcnt_nxt_s = (bcnt_r == BCNT_LAST) ? {BCNT_W{1'b0}} : (bcnt_r + BCNT_ONE);
    assign wrap_s     = tick_s & (bcnt_r == BCNT_LAST);
    assign decide_s   = tick_s & (bcnt_nxt_s == VOTE_C);
    assign vote_s     = maj3(vote_a_r, vote_b_r, sync2_r);

    // Tick counter within one bit period
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            bcnt_r <= {BCNT_W{1'b0}};
        end else if (restart_s) begin
            bcnt_r <= {BCNT_W{1'b0}};
        end else if (tick_s) begin
            bcnt_r <= bcnt_nxt_s;
        end else begin
            bcnt_r <= bcnt_r;
        end
    end

    // First two of the three voting samples
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            vote_a_r <= 1'b1;
            vote_b_r <= 1'b1;
        end else begin
            if (tick_s && (bcnt_nxt_s == VOTE_A)) begin
                vote_a_r <= sync2_r;
            end else begin
                vote_a_r <= vote_a_r;
            end
            if (tick_s && (bcnt_nxt_s == VOTE_B)) begin
                vote_b_r <= sync2_r;
            end else begin
                vote_b_r <= vote_b_r;
            end
        end
    end

    // FSM state register
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and control strobes
    always_comb begin
        state_nxt_s = state_r;
        restart_s   = 1'b0;
        idx_clr_s   = 1'b0;
        idx_inc_s   = 1'b0;
        bit_wr_s    = 1'b0;
        load_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_nxt_s = ST_START;
                    restart_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (decide_s && vote_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (wrap_s) begin
                    state_nxt_s = ST_DATA;
                    idx_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (decide_s) begin
                    bit_wr_s = 1'b1;
                end else begin
                    bit_wr_s = 1'b0;
                end
                if (wrap_s && (idx_r == IDX_LAST)) begin
                    state_nxt_s = ST_STOP;
                end else if (wrap_s) begin
                    idx_inc_s = 1'b1;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (decide_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Data bit index and shift register
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            idx_r   <= {IDX_W{1'b0}};
            shift_r <= {FRAME_WIDTH{1'b0}};
        end else begin
            if (idx_clr_s) begin
                idx_r <= {IDX_W{1'b0}};
            end else if (idx_inc_s) begin
                idx_r <= idx_r + IDX_ONE;
            end else begin
                idx_r <= idx_r;
            end
            if (bit_wr_s) begin
                shift_r[idx_r] <= vote_s;
            end else begin
                shift_r <= shift_r;
            end
        end
    end

    // Registered host-side outputs; dout only moves on a done cycle
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            dout_r <= {FRAME_WIDTH{1'b0}};
            done_r <= 1'b0;
            err_r  <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            done_r <= load_s;
            err_r  <= load_s & ~vote_s;
            busy_r <= (state_nxt_s != ST_IDLE);
            if (load_s) begin
                dout_r <= shift_r;
            end else begin
                dout_r <= dout_r;
            end
        end
    end

    assign uart_rx_dout      = dout_r;
    assign uart_rx_done      = done_r;
    assign uart_rx_frame_err = err_r;
    assign uart_rx_busy      = busy_r;

endmodule

// File: tb/tb_uart_rx_top.sv
// Directed bench for uart_rx_top at DIV=4 (64 clocks per bit): nominal, back-to-back,
// glitch, framing error/break, mid-frame reset, baud drift and sample-flip frames.
module tb_uart_rx_top;

    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       din;
    logic [0:7] dout;
    logic       done, ferr, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0, err_cnt = 0, dbl_cnt = 0, orphan_err = 0, chg_cnt = 0;
    int done_cyc = 0, busy_rise_cyc = 0, start_cyc = 0;
    logic       last_err  = 1'b0;
    logic       prev_done = 1'b0, prev_busy = 1'b0, prev_rst = 1'b0;
    logic [0:7] prev_dout = 8'h00;

    always #5 clk = ~clk;

    uart_rx_top #(
        .SYS_CLK_FREQ (640_000),
        .BAUD_RATE    (10_000),
        .FRAME_WIDTH  (8),
        .OVERSAMPLE   (16)
    ) dut (
        .sys_clk           (clk),
        .reset             (reset),
        .uart_rx_din       (din),
        .uart_rx_dout      (dout),
        .uart_rx_done      (done),
        .uart_rx_frame_err (ferr),
        .uart_rx_busy      (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Event capture for pulse counting and hold checks
    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            last_err <= ferr;
            if (ferr) err_cnt <= err_cnt + 1;
        end
        if (ferr && !done) orphan_err <= orphan_err + 1;
        if (done && prev_done) dbl_cnt <= dbl_cnt + 1;
        if (busy && !prev_busy) busy_rise_cyc <= cyc;
        if (reset && prev_rst && !done && (dout !== prev_dout)) chg_cnt <= chg_cnt + 1;
        prev_done <= done;
        prev_busy <= busy;
        prev_rst  <= reset;
        prev_dout <= dout;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives start, seq[0..7], stop; optional mid-bit flip and reset pulse in bit rst_bit
    task automatic send(input logic [0:7] seq, input logic stop, input int bclk,
                        input logic glitch, input int rst_bit);
        logic [0:9] b;
        b = {1'b0, seq, stop};
        start_cyc = cyc;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < bclk; j++) begin
                if (glitch && j >= 28 && j < 31) din = ~b[k];
                else din = b[k];
                if (k == rst_bit && j == 10) reset = 1'b0;
                if (k == rst_bit && j == 15) reset = 1'b1;
                if (k == rst_bit && j == 12) begin
                    chk("rst_mid_dout", 32'(dout), 32'h0);
                    chk("rst_mid_done", 32'(done), 32'h0);
                    chk("rst_mid_ferr", 32'(ferr), 32'h0);
                    chk("rst_mid_busy", 32'(busy), 32'h0);
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        din   = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_dout", 32'(dout), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_ferr", 32'(ferr), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // Nominal frame with latency checks
        send(8'b10100101, 1'b1, BIT, 1'b0, -1);
        chk("t1_dout", 32'(dout), 32'(8'b10100101));
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_ferr", 32'(last_err), 32'h0);
        chk("t1_busy_after", 32'(busy), 32'h0);
        chk("t1_busy_latency", 32'(busy_rise_cyc - start_cyc), 32'd3);
        chk("t1_done_latency", 32'(done_cyc - start_cyc), 32'd616);
        repeat (30) @(negedge clk);

        // Back-to-back, no idle gap
        send(8'h00, 1'b1, BIT, 1'b0, -1);
        chk("b2b_dout0", 32'(dout), 32'h00);
        chk("b2b_cnt0", 32'(done_cnt), 32'd2);
        send(8'hFF, 1'b1, BIT, 1'b0, -1);
        chk("b2b_dout1", 32'(dout), 32'hFF);
        chk("b2b_cnt1", 32'(done_cnt), 32'd3);
        repeat (30) @(negedge clk);

        // 20-clock low glitch: START entered, then rejected at the decision tick
        din = 1'b0;
        repeat (20) @(negedge clk);
        din = 1'b1;
        repeat (10) @(negedge clk);
        chk("glitch_busy_start", 32'(busy), 32'h1);
        repeat (20) @(negedge clk);
        chk("glitch_busy_end", 32'(busy), 32'h0);
        chk("glitch_no_done", 32'(done_cnt), 32'd3);
        chk("glitch_dout_hold", 32'(dout), 32'hFF);
        repeat (30) @(negedge clk);

        // Framing error followed by a held-low break
        send(8'b11110000, 1'b0, BIT, 1'b0, -1);
        chk("ferr_dout", 32'(dout), 32'(8'b11110000));
        chk("ferr_done_cnt", 32'(done_cnt), 32'd4);
        chk("ferr_err_cnt", 32'(err_cnt), 32'd1);
        chk("ferr_with_done", 32'(last_err), 32'h1);
        repeat (400) @(negedge clk);
        chk("break_busy", 32'(busy), 32'h0);
        chk("break_no_done", 32'(done_cnt), 32'd4);
        din = 1'b1;
        repeat (40) @(negedge clk);
        send(8'b01101001, 1'b1, BIT, 1'b0, -1);
        chk("post_break_dout", 32'(dout), 32'(8'b01101001));
        chk("post_break_cnt", 32'(done_cnt), 32'd5);
        chk("post_break_ferr", 32'(last_err), 32'h0);
        repeat (30) @(negedge clk);

        // Reset during data bit 4, then a clean 0x3C frame
        send(8'b00001111, 1'b1, BIT, 1'b0, 5);
        chk("abort_no_done", 32'(done_cnt), 32'd5);
        chk("abort_dout", 32'(dout), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        repeat (30) @(negedge clk);
        send(8'b00111100, 1'b1, BIT, 1'b0, -1);
        chk("x3c_dout", 32'(dout), 32'(8'b00111100));
        chk("x3c_cnt", 32'(done_cnt), 32'd6);
        repeat (30) @(negedge clk);

        // Baud drift of about -3% and +3%
        send(8'b11010010, 1'b1, 62, 1'b0, -1);
        chk("fast_dout", 32'(dout), 32'(8'b11010010));
        chk("fast_cnt", 32'(done_cnt), 32'd7);
        repeat (30) @(negedge clk);
        send(8'b11010010, 1'b1, 66, 1'b0, -1);
        chk("slow_dout", 32'(dout), 32'(8'b11010010));
        chk("slow_cnt", 32'(done_cnt), 32'd8);
        repeat (30) @(negedge clk);

        // One of three voted samples flipped in every bit
        send(8'b10011010, 1'b1, BIT, 1'b1, -1);
        chk("flip_dout", 32'(dout), 32'(8'b10011010));
        chk("flip_cnt", 32'(done_cnt), 32'd9);
        chk("flip_ferr", 32'(last_err), 32'h0);
        repeat (30) @(negedge clk);

        chk("done_single_cycle", 32'(dbl_cnt), 32'd0);
        chk("ferr_only_with_done", 32'(orphan_err), 32'd0);
        chk("dout_hold_between", 32'(chg_cnt), 32'd0);
        chk("total_ferr", 32'(err_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_top.md
# uart_rx_top

Receive half of the UART: recovers FRAME_WIDTH-bit frames from the asynchronous serial line using a 16x oversampling tick, then presents each frame on a parallel bus with a one-cycle done pulse. It is the counterpart of the transmit top and uses the same frame format: 1 start bit (0), FRAME_WIDTH data bits with index 0 first, and 1 stop bit (1). It sits between the board RX pin and the host logic, in the sys_clk domain.

## Interface
- SYS_CLK_FREQ, 200_000_000, system clock frequency in Hz
- BAUD_RATE, 19200, line rate (9600/19200/38400/57600/115200)
- FRAME_WIDTH, 8, data bits per frame
- OVERSAMPLE, 16, ticks per bit; even, >= 8
- sys_clk  in  1  single clock for the whole block
- reset  in  1  asynchronous, active-low (asserted at 0)
- uart_rx_din  in  1  serial line; idle high; asynchronous to sys_clk
- uart_rx_dout  out  [0:FRAME_WIDTH-1]  last received frame; bit 0 = first data bit on the line
- uart_rx_done  out  1  one-cycle pulse when uart_rx_dout is updated
- uart_rx_frame_err  out  1  one-cycle pulse, coincident with done, when the stop bit sampled 0
- uart_rx_busy  out  1  high from start-edge detection until the frame is finished or aborted

## Operation
- Tick generator: DIV = SYS_CLK_FREQ / (BAUD_RATE*OVERSAMPLE), integer floor, minimum 1. It emits a one-sys_clk enable pulse every DIV cycles. It is not a derived clock. It is free-running except that it restarts at 0 on start-edge detection.
- Input path: 2-FF synchronizer (reset value 1), then a third FF for edge detection. Falling edge = prev 1, current 0.
- Bit counter bcnt counts ticks 0..OVERSAMPLE-1 within a bit. It is cleared on start-edge detection and wraps at the end of each bit.
- Voting: the synced line is sampled at bcnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the 2-of-3 majority, decided at the OVERSAMPLE/2+1 tick.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: falling edge -> START; clear bcnt and the tick divider; busy=1.
  - START: at the decision tick, a majority of 1 is a false start -> IDLE (busy=0, no pulses). A majority of 0 -> DATA at the next bcnt wrap, with data index 0.
  - DATA: at each decision tick, write the voted bit into shift[idx]. After idx = FRAME_WIDTH-1, go to STOP at the bcnt wrap.
  - STOP: at the decision tick, load uart_rx_dout from shift and pulse done. Pulse frame_err too if the vote was 0. Go to IDLE in the same cycle with busy=0. The remaining half stop bit is not waited out.
- After a framing error with the line held low (break), no new frame starts until the line returns high and falls again.
- uart_rx_dout holds its value between frames. It changes only on a done cycle.

## Timing
- Reset values: uart_rx_dout=0, uart_rx_done=0, uart_rx_frame_err=0, uart_rx_busy=0, FSM=IDLE, synchronizer FFs=1.
- Reset asserted mid-frame: the frame is discarded immediately and no done is produced. After release, the block waits in IDLE for a fresh falling edge.
- Edge-detect latency: 3 sys_clk cycles from a line transition to busy=1.
- Done timing: done rises (FRAME_WIDTH+1)*OVERSAMPLE + OVERSAMPLE/2+1 ticks after start detection, plus at most 1 cycle of register latency. It is high for exactly 1 sys_clk cycle.
- Register timing: done, frame_err and dout update on the same clock edge.
- Tolerance: the vote centre is at mid-bit, giving at least ±(OVERSAMPLE/2-2)/OVERSAMPLE of a bit of accumulated drift over a frame.
- No backpressure: the host must consume uart_rx_dout before the next done. An unread frame is overwritten silently.

## Structure
- Shared package/header: state encodings (IDLE/START/DATA/STOP), and DIV and counter widths derived via $clog2 from the parameters.
- Sub-module uart_rx_clk_gen: tick enable generator with a sync-restart input, parameters SYS_CLK_FREQ, BAUD_RATE, OVERSAMPLE.
- Main body: the synchronizer, voting, FSM and shift register live in uart_rx_top.
- Expected size: roughly 150-250 lines total.

## Test plan
Use SYS_CLK_FREQ=640_000, BAUD_RATE=10_000, OVERSAMPLE=16, FRAME_WIDTH=8, giving DIV=4 and 64 clocks per bit.
- Frame 1,0,1,0,0,1,0,1 then stop 1 -> dout=[0:7]=10100101, one done pulse, frame_err=0, busy low afterwards.
- Back-to-back frames 0x00 and 0xFF with no idle gap -> two done pulses with correct dout, no missed start.
- 20-clock low glitch on an idle line -> no done, busy returns to 0 at the START decision, FSM in IDLE.
- Stop bit driven 0 with data 11110000 -> done and frame_err pulse in the same cycle, dout=11110000. The line held low afterwards produces no further frames until high then low.
- reset driven to 0 during data bit 4 for 5 clocks, then a clean 0x3C frame -> no done for the aborted frame, correct dout for 0x3C, all outputs 0 during reset.
- Bit periods of the same frame stretched and shrunk by ±3% -> correct dout in both cases. One voted sample per bit flipped -> dout unaffected.
